dram_pad_drv_ctl: RTL and testbench
===================================

# dram_pad_drv_ctl

Drive-strength sequencer for the DRAM SSTL pads. It accepts a new pull-up/pull-down impedance target (`cbu`/`cbd` thermometer codes) from the calibration engine. It then walks the live pad codes toward that target one thermometer bit per step, and only while the DRAM controller grants a safe window, so the pad drivers never see a multi-bit strength jump. It sits between pad calibration and every data, strobe and clock pad slice, whose `cbu[8:1]`/`cbd[8:1]` inputs it drives.

## Interface
Parameters:
- `STEP_GAP`, 4: idle cycles inserted after each step (1..15).
- `RST_CODE`, 8'b0000_1111: reset value of `cbu` and `cbd`. Must be a valid thermometer code.

Ports:
- `clk` input 1: core clock. The block has one clock.
- `rst_l` input 1: asynchronous, active-low reset.
- `cal_req` input 1: new target valid. Held high until `cal_ack`.
- `cal_cbu` input [8:1]: target pull-up code.
- `cal_cbd` input [8:1]: target pull-down code.
- `cal_ack` output 1: one-cycle pulse; the request has been consumed.
- `cal_err` output 1: one-cycle pulse with `cal_ack`; the target was rejected.
- `safe_win` input 1: a step may be applied this cycle.
- `cbu` output [8:1]: live pull-up code to the pads.
- `cbd` output [8:1]: live pull-down code to the pads.
- `busy` output 1: a sequence is in progress.
- `done` output 1: one-cycle pulse when the target has been reached.

## Operation
- Reset values: `cbu`=`cbd`=`RST_CODE`; `cal_ack`, `cal_err`, `busy` and `done` = 0. The state machine goes to IDLE and the gap counter to 0. All outputs are registered.
- Valid thermometer code: 0s above a contiguous run of 1s starting at bit 1, including all-0 and all-1. Its level is the number of 1s (0..8).

State machine:
- **IDLE**
  - On `cal_req`=1 with `cal_ack`=0: pulse `cal_ack`.
  - If either target is not a valid thermometer code: pulse `cal_err` and stay in IDLE. The outputs do not change.
  - Otherwise: latch both targets and go to WAIT_WIN.
- **WAIT_WIN**
  - If `cbu`==target and `cbd`==target: pulse `done` and go to IDLE.
  - Else if `safe_win`=1: apply one step and go to GAP with the counter set to `STEP_GAP`.
  - Else: hold.
- **GAP**: decrement the counter; at 1, go to WAIT_WIN. `safe_win` is ignored in GAP.

Step rules:
- A step moves `cbu` and `cbd` independently and simultaneously.
- Level below target: set the lowest 0 bit.
- Level above target: clear the highest 1 bit.
- Level equal to target: no change.
- The result is always thermometer and changes by at most one bit per code.

Other rules:
- `busy` = (state != IDLE).
- `cal_req` is ignored while `busy`. The requester holds it until `cal_ack`.
- A `cal_req` still high in the cycle `cal_ack` is high is not treated as a new request.
- `rst_l` asserted mid-sequence immediately returns the codes to `RST_CODE` and abandons the target. No `done` is produced.

## Timing
Request handshake:
- `cal_req` is sampled high in IDLE in cycle n.
- `cal_ack` (and `cal_err` if the target is rejected) is high in cycle n+1.
- In cycle n+1 the state is WAIT_WIN (valid target) or IDLE (rejected target).

Steps:
- A step decided in cycle k is visible on `cbu`/`cbd` in cycle k+1.
- With `safe_win` held at 1, consecutive steps are `STEP_GAP`+1 cycles apart.
- First-step latency from a request in cycle n is a visible change in cycle n+2.

Completion:
- The match is detected in WAIT_WIN in cycle m.
- `done` is high and `busy` is low in cycle m+1.

## Configuration
- `DRAM_PAD_DRV_STATS_EN` defined: adds output `step_cnt` [7:0].
  - Counts cycles in which a step changed `cbu` or `cbd`.
  - Saturates at 8'hFF.
  - Resets to 0 on `rst_l` only.
- `DRAM_PAD_DRV_STATS_EN` undefined: the `step_cnt` port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset: assert `rst_l`=0 → `cbu`=`cbd`=8'h0F, `busy`=0, `done`=0, `cal_ack`=0.
- Full walk (`STEP_GAP`=4, `safe_win`=1): request `cal_cbu`=8'hFF, `cal_cbd`=8'h03 in cycle n →
  - `cal_ack` in cycle n+1.
  - `cbu` is 1F/3F/7F/FF in cycles n+2/n+7/n+12/n+17.
  - `cbd` is 07/03 in cycles n+2/n+7.
  - `done` pulses in cycle n+22 and `busy` drops in cycle n+22.
- Invalid target: `cal_cbu`=8'h5A → `cal_ack` and `cal_err` both high in cycle n+1, codes unchanged, `busy` stays 0.
- Window stall: drop `safe_win` after the first step (`cbu`=1F) for 20 cycles → no code change during the stall. The next step follows within 1 cycle of `safe_win` returning, if the state is WAIT_WIN.
- Null request: the target equals the current codes (0F/0F) → `cal_ack` in n+1, `done` in n+2, codes never toggle.
- Reset mid-sequence with `cbu`=3F: pulse `rst_l` low → `cbu`=0F immediately, no `done`. With `DRAM_PAD_DRV_STATS_EN`, `step_cnt`=0.

Source files
------------

// File: rtl/dram_pad_drv_ctl.sv
// dram_pad_drv_ctl: walks the live SSTL pad drive codes (cbu/cbd) toward a
// calibration target one thermometer bit per step, stepping only inside a
// controller-granted safe window and spacing steps by STEP_GAP idle cycles.
// Optional: define DRAM_PAD_DRV_STATS_EN to add the step_cnt statistics port.
module dram_pad_drv_ctl #(
    parameter int          STEP_GAP = 4,
    parameter logic [8:1]  RST_CODE = 8'b0000_1111
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       cal_req,
    input  logic [8:1] cal_cbu,
    input  logic [8:1] cal_cbd,
    output logic       cal_ack,
    output logic       cal_err,
    input  logic       safe_win,
    output logic [8:1] cbu,
    output logic [8:1] cbd,
    output logic       busy,
    output logic       done
`ifdef DRAM_PAD_DRV_STATS_EN
    ,
    output logic [7:0] step_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_WIN, GAP} state_t;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [8:1] tgt_u_reg, tgt_u_next, tgt_d_reg, tgt_d_next;
    logic [8:1] cbu_reg, cbu_next, cbd_reg, cbd_next;
    logic       ack_reg, ack_next, err_reg, err_next;
    logic       done_reg, done_next, busy_reg, busy_next;

    // Per-bit helpers: one-step-up / one-step-down codes and validity checks.
    logic [8:1] up_u, dn_u, up_d, dn_d;
    logic [8:1] bad_u, bad_d;
    logic       valid_u, valid_d;
    logic [8:1] step_u, step_d;

    generate
        for (genvar gi = 1; gi <= 8; gi++) begin : g_bit
            if (gi == 1) begin : g_lo
                // Setting the lowest 0 of a thermometer code always sets bit 1.
                assign up_u[gi]  = 1'b1;
                assign up_d[gi]  = 1'b1;
                assign bad_u[gi] = 1'b0;
                assign bad_d[gi] = 1'b0;
            end else begin : g_hi
                assign up_u[gi]  = cbu_reg[gi] | cbu_reg[gi-1];
                assign up_d[gi]  = cbd_reg[gi] | cbd_reg[gi-1];
                // A 1 sitting above a 0 breaks the contiguous run.
                assign bad_u[gi] = cal_cbu[gi] & ~cal_cbu[gi-1];
                assign bad_d[gi] = cal_cbd[gi] & ~cal_cbd[gi-1];
            end
            if (gi == 8) begin : g_top
                assign dn_u[gi] = 1'b0;
                assign dn_d[gi] = 1'b0;
            end else begin : g_mid
                // Clearing the highest 1 is a one-bit shift down of the run.
                assign dn_u[gi] = cbu_reg[gi+1];
                assign dn_d[gi] = cbd_reg[gi+1];
            end
        end
    endgenerate

    assign valid_u = ~|bad_u;
    assign valid_d = ~|bad_d;

    // Thermometer codes order the same as their levels, so a plain compare works.
    assign step_u = (cbu_reg < tgt_u_reg) ? up_u :
                    (cbu_reg > tgt_u_reg) ? dn_u : cbu_reg;
    assign step_d = (cbd_reg < tgt_d_reg) ? up_d :
                    (cbd_reg > tgt_d_reg) ? dn_d : cbd_reg;

    // Next-state and output decode for the handshake/step/gap sequencer.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tgt_u_next = tgt_u_reg;
        tgt_d_next = tgt_d_reg;
        cbu_next   = cbu_reg;
        cbd_next   = cbd_reg;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // ack_reg high means this cal_req is the tail of the last request.
                if (cal_req && !ack_reg) begin
                    ack_next = 1'b1;
                    if (!(valid_u && valid_d)) begin
                        err_next = 1'b1;
                    end else begin
                        tgt_u_next = cal_cbu;
                        tgt_d_next = cal_cbd;
                        state_next = WAIT_WIN;
                    end
                end
            end
            WAIT_WIN: begin
                if (cbu_reg == tgt_u_reg && cbd_reg == tgt_d_reg) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (safe_win) begin
                    cbu_next   = step_u;
                    cbd_next   = step_d;
                    cnt_next   = 4'(STEP_GAP);
                    state_next = GAP;
                end
            end
            GAP: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = WAIT_WIN;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            tgt_u_reg <= RST_CODE;
            tgt_d_reg <= RST_CODE;
            cbu_reg   <= RST_CODE;
            cbd_reg   <= RST_CODE;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tgt_u_reg <= tgt_u_next;
            tgt_d_reg <= tgt_d_next;
            cbu_reg   <= cbu_next;
            cbd_reg   <= cbd_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
        end
    end

    assign cal_ack = ack_reg;
    assign cal_err = err_reg;
    assign cbu     = cbu_reg;
    assign cbd     = cbd_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

`ifdef DRAM_PAD_DRV_STATS_EN
    logic [7:0] step_cnt_reg;
    // Saturating count of cycles in which a step actually moved a code.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            step_cnt_reg <= 8'd0;
        end else if (((cbu_next != cbu_reg) || (cbd_next != cbd_reg)) &&
                     (step_cnt_reg != 8'hFF)) begin
            step_cnt_reg <= step_cnt_reg + 8'd1;
        end
    end
    assign step_cnt = step_cnt_reg;
`endif

endmodule

// File: tb/tb_dram_pad_drv_ctl.sv
// tb_dram_pad_drv_ctl: scenario tasks plus randomized requests checked against
// a level-based schedule model of the pad code sequencer.
module tb_dram_pad_drv_ctl;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       cal_req = 1'b0;
    logic [8:1] cal_cbu = 8'h0F;
    logic [8:1] cal_cbd = 8'h0F;
    logic       safe_win = 1'b1;
    logic       cal_ack, cal_err, busy, done;
    logic [8:1] cbu, cbd;
`ifdef DRAM_PAD_DRV_STATS_EN
    logic [7:0] step_cnt;
`endif

    int total = 0;
    int bad = 0;
    int cur_u = 4;
    int cur_d = 4;

    always #5 clk = ~clk;

    dram_pad_drv_ctl #(.STEP_GAP(4), .RST_CODE(8'b0000_1111)) dut (
        .clk(clk), .rst_l(rst_l), .cal_req(cal_req), .cal_cbu(cal_cbu),
        .cal_cbd(cal_cbd), .cal_ack(cal_ack), .cal_err(cal_err),
        .safe_win(safe_win), .cbu(cbu), .cbd(cbd), .busy(busy), .done(done)
`ifdef DRAM_PAD_DRV_STATS_EN
        , .step_cnt(step_cnt)
`endif
    );

    function automatic logic [8:1] lvl2code(input int l);
        logic [8:0] t;
        t = (9'd1 << l) - 9'd1;
        return t[7:0];
    endfunction

    function automatic int code2lvl(input logic [8:1] c);
        for (int l = 0; l <= 8; l++) if (lvl2code(l) == c) return l;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_l = 1'b0;
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        cur_u = 4;
        cur_d = 4;
    endtask

    // Request presented in cycle n; each later @negedge is cycle n+k.
    task automatic issue(input logic [8:1] u, input logic [8:1] d);
        @(posedge clk);
        #1;
        cal_cbu = u;
        cal_cbd = d;
        cal_req = 1'b1;
        $display("txn req cbu=%h cbd=%h", u, d);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        total++; if (cbu !== 8'h0F) begin bad++; $display("FAIL reset_cbu got=%h exp=0f", cbu); end
        total++; if (cbd !== 8'h0F) begin bad++; $display("FAIL reset_cbd got=%h exp=0f", cbd); end
        total++; if ({busy, done, cal_ack, cal_err} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, cal_ack, cal_err}); end
`ifdef DRAM_PAD_DRV_STATS_EN
        total++; if (step_cnt !== 8'd0) begin bad++; $display("FAIL reset_stepcnt got=%0d exp=0", step_cnt); end
`endif
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        cur_u = 4; cur_d = 4;
    endtask

    task automatic test_full_walk();
        logic [8:1] eu, ed;
        issue(8'hFF, 8'h03);
        for (int k = 1; k <= 24; k++) begin
            next_cycle();
            eu = (k < 2) ? 8'h0F : (k < 7) ? 8'h1F : (k < 12) ? 8'h3F : (k < 17) ? 8'h7F : 8'hFF;
            ed = (k < 2) ? 8'h0F : (k < 7) ? 8'h07 : 8'h03;
            total++; if (cal_ack !== (k == 1)) begin bad++; $display("FAIL walk_ack k=%0d got=%b", k, cal_ack); end
            total++; if (cbu !== eu) begin bad++; $display("FAIL walk_cbu k=%0d got=%h exp=%h", k, cbu, eu); end
            total++; if (cbd !== ed) begin bad++; $display("FAIL walk_cbd k=%0d got=%h exp=%h", k, cbd, ed); end
            total++; if (done !== (k == 22)) begin bad++; $display("FAIL walk_done k=%0d got=%b", k, done); end
            total++; if (busy !== (k < 22)) begin bad++; $display("FAIL walk_busy k=%0d got=%b", k, busy); end
            if (k == 1) cal_req = 1'b0;
        end
`ifdef DRAM_PAD_DRV_STATS_EN
        total++; if (step_cnt !== 8'd4) begin bad++; $display("FAIL walk_stepcnt got=%0d exp=4", step_cnt); end
`endif
        cur_u = 8; cur_d = 2;
    endtask

    task automatic test_invalid();
        issue(8'h5A, 8'h03);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            total++; if (cal_ack !== (k == 1)) begin bad++; $display("FAIL inv_ack k=%0d got=%b", k, cal_ack); end
            total++; if (cal_err !== (k == 1)) begin bad++; $display("FAIL inv_err k=%0d got=%b", k, cal_err); end
            total++; if ({cbu, cbd} !== {8'hFF, 8'h03}) begin bad++; $display("FAIL inv_codes k=%0d got=%h/%h exp=ff/03", k, cbu, cbd); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL inv_busy k=%0d got=%b exp=0", k, busy); end
            if (k == 1) cal_req = 1'b0;
        end
    endtask

    task automatic test_null();
        do_reset();
        issue(8'h0F, 8'h0F);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            total++; if (cal_ack !== (k == 1)) begin bad++; $display("FAIL null_ack k=%0d got=%b", k, cal_ack); end
            total++; if (done !== (k == 2)) begin bad++; $display("FAIL null_done k=%0d got=%b", k, done); end
            total++; if ({cbu, cbd} !== {8'h0F, 8'h0F}) begin bad++; $display("FAIL null_codes k=%0d got=%h/%h exp=0f/0f", k, cbu, cbd); end
            total++; if (busy !== (k == 1)) begin bad++; $display("FAIL null_busy k=%0d got=%b", k, busy); end
            if (k == 1) cal_req = 1'b0;
        end
    endtask

    task automatic test_stall();
        bit seen = 0;
        issue(8'hFF, 8'h0F);
        for (int k = 1; k <= 23; k++) begin
            next_cycle();
            if (k == 1) cal_req = 1'b0;
            if (k >= 2 && k <= 22) begin
                total++; if (cbu !== 8'h1F) begin bad++; $display("FAIL stall_hold k=%0d got=%h exp=1f", k, cbu); end
            end
            if (k == 2) safe_win = 1'b0;
            if (k == 22) safe_win = 1'b1;
            if (k == 23) begin
                total++; if (cbu !== 8'h3F) begin bad++; $display("FAIL stall_resume got=%h exp=3f", cbu); end
            end
        end
        for (int c = 0; c < 100 && !seen; c++) begin
            next_cycle();
            if (done === 1'b1) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL stall_done_timeout got=0 exp=1"); end
        total++; if ({cbu, cbd} !== {8'hFF, 8'h0F}) begin bad++; $display("FAIL stall_final got=%h/%h exp=ff/0f", cbu, cbd); end
        cur_u = 8; cur_d = 4;
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        do_reset();
        issue(8'hFF, 8'h0F);
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            if (k == 1) cal_req = 1'b0;
        end
        total++; if (cbu !== 8'h3F) begin bad++; $display("FAIL mid_pre got=%h exp=3f", cbu); end
        rst_l = 1'b0;
        #1;
        total++; if (cbu !== 8'h0F) begin bad++; $display("FAIL mid_cbu got=%h exp=0f", cbu); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
`ifdef DRAM_PAD_DRV_STATS_EN
        total++; if (step_cnt !== 8'd0) begin bad++; $display("FAIL mid_stepcnt got=%0d exp=0", step_cnt); end
`endif
        @(negedge clk);
        rst_l = 1'b1;
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            if (done === 1'b1 || cbu !== 8'h0F) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL mid_after got=activity exp=quiet"); end
        cur_u = 4; cur_d = 4;
    endtask

    task automatic test_random();
        for (int it = 0; it < 14; it++) begin
            int tu, td, du, dd, s, a, lu, ld, n;
            logic [8:1] u, d, junk;
            tu = $urandom_range(0, 8);
            td = $urandom_range(0, 8);
            u = lvl2code(tu);
            d = lvl2code(td);
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom);
                if (code2lvl(junk) >= 0) junk = 8'hA5;
                if ($urandom_range(0, 1) == 0) u = junk; else d = junk;
            end
            issue(u, d);
            if (code2lvl(u) < 0 || code2lvl(d) < 0) begin
                for (int k = 1; k <= 3; k++) begin
                    next_cycle();
                    if (k == 1) cal_req = 1'b0;
                    total++; if ({cal_ack, cal_err} !== {2{k == 1}}) begin bad++; $display("FAIL rnd_inv_ack it=%0d k=%0d got=%b", it, k, {cal_ack, cal_err}); end
                    total++; if ({cbu, cbd} !== {lvl2code(cur_u), lvl2code(cur_d)}) begin bad++; $display("FAIL rnd_inv_codes it=%0d got=%h/%h", it, cbu, cbd); end
                end
            end else begin
                du = (tu > cur_u) ? tu - cur_u : cur_u - tu;
                dd = (td > cur_d) ? td - cur_d : cur_d - td;
                s = (du > dd) ? du : dd;
                n = 2 + 5 * s;
                for (int k = 1; k <= n + 1; k++) begin
                    next_cycle();
                    if (k == 1) cal_req = 1'b0;
                    a = (k >= 2) ? (k - 2) / 5 + 1 : 0;
                    if (a > s) a = s;
                    lu = (tu > cur_u) ? cur_u + ((a < du) ? a : du) : cur_u - ((a < du) ? a : du);
                    ld = (td > cur_d) ? cur_d + ((a < dd) ? a : dd) : cur_d - ((a < dd) ? a : dd);
                    total++; if ({cbu, cbd} !== {lvl2code(lu), lvl2code(ld)}) begin bad++; $display("FAIL rnd_codes it=%0d k=%0d got=%h/%h exp=%h/%h", it, k, cbu, cbd, lvl2code(lu), lvl2code(ld)); end
                    total++; if ({cal_ack, cal_err} !== {k == 1, 1'b0}) begin bad++; $display("FAIL rnd_ack it=%0d k=%0d got=%b", it, k, {cal_ack, cal_err}); end
                    total++; if (done !== (k == n)) begin bad++; $display("FAIL rnd_done it=%0d k=%0d got=%b", it, k, done); end
                    total++; if (busy !== (k < n)) begin bad++; $display("FAIL rnd_busy it=%0d k=%0d got=%b", it, k, busy); end
                end
                cur_u = tu;
                cur_d = td;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_walk();
        test_invalid();
        test_null();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
